// File: rtl/sprite_dma_ctrl.sv
// sprite_dma_ctrl: on each vblank rise, halts the CPU and copies the 16 attribute bytes
// and 16 coordinate bytes from main RAM into sprite RAM, one byte per cycle.
module sprite_dma_ctrl #(
    parameter logic [15:0] ATTR_BASE   = 16'h4FF0,
    parameter logic [15:0] COORD_BASE  = 16'h5060,
    parameter int          N_SPR_BYTES = 16,
    parameter logic [7:0]  HALT_TMO    = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    input  logic        cpu_halted,
    output logic        gpu_pause,
    output logic [15:0] ram_addr,
    input  logic [7:0]  ram_dout,
    output logic        spr_wr_en,
    output logic [4:0]  spr_addr,
    output logic [7:0]  spr_din,
    output logic        dma_busy,
    output logic        frame_done,
    output logic        late_err,
    output logic [7:0]  skip_cnt
);
    localparam int TOTAL = 2 * N_SPR_BYTES;
    localparam int IW = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, REQ, COPY, DRAIN} state_t;

    state_t         state, state_nx;
    logic           vblank_q;
    logic [7:0]     tmo_cnt;
    logic [IW-1:0]  idx;
    logic [15:0]    addr_q;
    logic [15:0]    addr_calc;
    logic           wr_en_q;
    logic [4:0]     wr_addr_q;
    logic           start;
    logic           timeout;
    logic           last_idx;

    assign start     = vblank & ~vblank_q;
    assign timeout   = tmo_cnt == HALT_TMO - 8'd1;
    assign last_idx  = idx == IW'(TOTAL - 1);
    assign addr_calc = (idx < IW'(N_SPR_BYTES)) ? ATTR_BASE + 16'(idx)
                                                : COORD_BASE + 16'(idx) - 16'(N_SPR_BYTES);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            vblank_q  <= 1'b0;
            tmo_cnt   <= '0;
            idx       <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            late_err  <= 1'b0;
            skip_cnt  <= '0;
        end else begin
            state     <= state_nx;
            vblank_q  <= vblank;
            tmo_cnt   <= (state == REQ) ? tmo_cnt + 8'd1 : '0;
            idx       <= (state == COPY) ? idx + IW'(1) : '0;
            addr_q    <= (state == COPY) ? addr_calc : addr_q;
            // read data returns one cycle after the address, so the write lags by one stage
            wr_en_q   <= state == COPY;
            wr_addr_q <= 5'(idx);
            if ((state == COPY || state == DRAIN) && !vblank)
                late_err <= 1'b1;
            if (state == REQ && !cpu_halted && timeout && skip_cnt != 8'hFF)
                skip_cnt <= skip_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = cpu_halted ? COPY : (timeout ? IDLE : REQ);
            COPY:    state_nx = last_idx ? DRAIN : COPY;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dma_busy   = state != IDLE;
        gpu_pause  = state != IDLE;
        frame_done = state == DRAIN;
        ram_addr   = (state == COPY) ? addr_calc : addr_q;
        spr_wr_en  = wr_en_q;
        spr_addr   = wr_addr_q;
        spr_din    = wr_en_q ? ram_dout : 8'h00;
    end
endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// tb_sprite_dma_ctrl: directed bench for sprite_dma_ctrl with a synthetic main-RAM model
// and a write logger whose contents are checked against the expected sprite copy.
module tb_sprite_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblank = 1'b0;
    logic        cpu_halted = 1'b0;
    logic        gpu_pause;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout = 8'h00;
    logic        spr_wr_en;
    logic [4:0]  spr_addr;
    logic [7:0]  spr_din;
    logic        dma_busy;
    logic        frame_done;
    logic        late_err;
    logic [7:0]  skip_cnt;

    int total = 0;
    int passed = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int pause_cyc = 0;
    logic [4:0] log_a [512];
    logic [7:0] log_d [512];

    sprite_dma_ctrl dut (
        .clk(clk), .rst(rst), .vblank(vblank), .cpu_halted(cpu_halted),
        .gpu_pause(gpu_pause), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .spr_wr_en(spr_wr_en), .spr_addr(spr_addr), .spr_din(spr_din),
        .dma_busy(dma_busy), .frame_done(frame_done), .late_err(late_err),
        .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]};
    endfunction

    function automatic logic [15:0] src_addr(input int i);
        return (i < 16) ? 16'h4FF0 + 16'(i) : 16'h5060 + 16'(i - 16);
    endfunction

    always @(posedge clk) ram_dout <= mem(ram_addr);

    always @(negedge clk) begin
        if (spr_wr_en && wr_cnt < 512) begin
            log_a[wr_cnt] = spr_addr;
            log_d[wr_cnt] = spr_din;
        end
        if (spr_wr_en) wr_cnt++;
        if (frame_done) fd_cnt++;
        if (gpu_pause) pause_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < 200), 1);
    endtask

    task automatic check_log(input string tag, input int base);
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (base + i >= 512) bad++;
            else if (log_a[base+i] !== 5'(i) || log_d[base+i] !== mem(src_addr(i))) bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

    initial begin
        int base_w, base_f, base_p;
        // reset state
        tick(3);
        chk("rst_pause", 32'(gpu_pause), 0);
        chk("rst_busy", 32'(dma_busy), 0);
        chk("rst_wr_en", 32'(spr_wr_en), 0);
        chk("rst_skip", 32'(skip_cnt), 0);
        chk("rst_late", 32'(late_err), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        rst = 1'b1;
        tick(2);

        // normal copy, halt acknowledged three cycles after the rise
        base_w = wr_cnt; base_f = fd_cnt; base_p = pause_cyc;
        vblank = 1'b1;
        tick(1);
        chk("t1_pause_up", 32'(gpu_pause), 1);
        chk("t1_busy_up", 32'(dma_busy), 1);
        tick(2);
        cpu_halted = 1'b1;
        wait_fd("t1_fd_timeout");
        tick(1);
        chk("t1_pause_down", 32'(gpu_pause), 0);
        chk("t1_writes", 32'(wr_cnt - base_w), 32);
        chk("t1_frame_done", 32'(fd_cnt - base_f), 1);
        chk("t1_pause_cycles", 32'(pause_cyc - base_p), 36);
        check_log("t1_data", base_w);
        chk("t1_late", 32'(late_err), 0);
        cpu_halted = 1'b0;
        vblank = 1'b0;
        tick(2);

        // halt never acknowledged: timeout and skip counting
        base_w = wr_cnt; base_p = pause_cyc;
        vblank = 1'b1;
        tick(1);
        begin
            int n = 0;
            while (gpu_pause === 1'b1 && n < 200) begin
                tick(1);
                n++;
            end
            chk("t2_tmo_timeout", 32'(n < 200), 1);
        end
        chk("t2_pause_cycles", 32'(pause_cyc - base_p), 64);
        chk("t2_skip1", 32'(skip_cnt), 1);
        vblank = 1'b0;
        tick(1);
        for (int f = 1; f < 300; f++) begin
            vblank = 1'b1;
            tick(1);
            vblank = 1'b0;
            tick(70);
            if (f == 254) chk("t2_skip255", 32'(skip_cnt), 255);
        end
        chk("t2_skip_sat", 32'(skip_cnt), 255);
        chk("t2_no_writes", 32'(wr_cnt - base_w), 0);

        // vblank falls ten cycles into the copy
        base_w = wr_cnt;
        vblank = 1'b1;
        cpu_halted = 1'b1;
        tick(2);
        tick(9);
        chk("t3_late_before", 32'(late_err), 0);
        tick(1);
        vblank = 1'b0;
        wait_fd("t3_fd_timeout");
        tick(1);
        chk("t3_writes", 32'(wr_cnt - base_w), 32);
        check_log("t3_data", base_w);
        chk("t3_late", 32'(late_err), 1);
        tick(20);
        chk("t3_late_sticky", 32'(late_err), 1);

        // reset on the fifth write cycle
        base_w = wr_cnt;
        vblank = 1'b1;
        tick(2);
        tick(5);
        chk("t4_fifth_addr", 32'(spr_addr), 4);
        rst = 1'b0;
        tick(1);
        chk("t4_pause", 32'(gpu_pause), 0);
        chk("t4_wr_en", 32'(spr_wr_en), 0);
        chk("t4_busy", 32'(dma_busy), 0);
        chk("t4_late_clr", 32'(late_err), 0);
        chk("t4_partial", 32'(wr_cnt - base_w), 5);
        rst = 1'b1;
        vblank = 1'b0;
        tick(2);
        base_w = wr_cnt;
        vblank = 1'b1;
        wait_fd("t4_fd_timeout");
        tick(1);
        chk("t4_writes", 32'(wr_cnt - base_w), 32);
        check_log("t4_restart", base_w);
        cpu_halted = 1'b0;
        vblank = 1'b0;
        tick(2);

        // extra rises during REQ and COPY are ignored
        base_w = wr_cnt; base_f = fd_cnt;
        vblank = 1'b1;
        tick(1);
        vblank = 1'b0;
        tick(1);
        vblank = 1'b1;
        tick(1);
        cpu_halted = 1'b1;
        tick(4);
        vblank = 1'b0;
        tick(1);
        vblank = 1'b1;
        tick(1);
        wait_fd("t5_fd_timeout");
        tick(10);
        chk("t5_writes", 32'(wr_cnt - base_w), 32);
        chk("t5_frame_done", 32'(fd_cnt - base_f), 1);
        check_log("t5_data", base_w);
        chk("t5_idle", 32'(dma_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
